// File: rtl/score_display_if.sv
// Signal bundle between the game control logic and the score/display block.
// The master drives ticks and game events; the slave returns score and pin values.
interface score_display_if;
   logic        score_tick;
   logic        fast_tick;
   logic        dp_tick;
   logic        blink_tick;
   logic        start;
   logic        game_over;
   logic        fast_mode;
   logic [15:0] score_bcd;
   logic [15:0] hi_bcd;
   logic [3:0]  an;
   logic [6:0]  seg;
   logic        dp;

   modport master (
      output score_tick, fast_tick, dp_tick, blink_tick, start, game_over, fast_mode,
      input  score_bcd, hi_bcd, an, seg, dp
   );

   modport slave (
      input  score_tick, fast_tick, dp_tick, blink_tick, start, game_over, fast_mode,
      output score_bcd, hi_bcd, an, seg, dp
   );
endinterface

// File: rtl/score_display.sv
// Dino game BCD score / high-score keeper and 4-digit multiplexed seven-segment driver.
// Shows hi in IDLE, the run score in RUN, and the run score blinking in OVER.
module score_display #(
   parameter bit SEG_ACTIVE_LOW = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   score_display_if.slave    sd_if
);

   typedef enum logic [1:0] {IDLE, RUN, OVER} state_e;

   localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW ? 7'h7f : 7'h00;

   state_e      state_q, state_d;
   logic [15:0] score_q, score_d;
   logic [15:0] hi_q, hi_d;
   logic [1:0]  idx_q, idx_d;
   logic        visible_q, visible_d;
   logic [3:0]  an_q, an_d;
   logic [6:0]  seg_q, seg_d;

   logic        inc;
   logic [15:0] shown;
   logic [3:0]  digit;
   logic        blank;
   logic [6:0]  pat;

   // Ripple BCD increment that saturates at 9999.
   function automatic logic [15:0] bcd_inc(input logic [15:0] v);
      logic [15:0] r;
      logic        carry;
      r     = v;
      carry = 1'b1;
      if (v != 16'h9999) begin
         for (int i = 0; i < 4; i++) begin
            if (carry) begin
               if (r[4*i +: 4] == 4'd9) begin
                  r[4*i +: 4] = 4'd0;
               end else begin
                  r[4*i +: 4] = r[4*i +: 4] + 4'd1;
                  carry       = 1'b0;
               end
            end
         end
      end
      return r;
   endfunction

   function automatic logic [6:0] seg_lo(input logic [3:0] d);
      case (d)
         4'd0:    seg_lo = 7'b1000000;
         4'd1:    seg_lo = 7'b1111001;
         4'd2:    seg_lo = 7'b0100100;
         4'd3:    seg_lo = 7'b0110000;
         4'd4:    seg_lo = 7'b0011001;
         4'd5:    seg_lo = 7'b0010010;
         4'd6:    seg_lo = 7'b0000010;
         4'd7:    seg_lo = 7'b1111000;
         4'd8:    seg_lo = 7'b0000000;
         4'd9:    seg_lo = 7'b0010000;
         default: seg_lo = 7'b1111111;
      endcase
   endfunction

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      state_d   = state_q;
      score_d   = score_q;
      hi_d      = hi_q;
      visible_d = visible_q;
      idx_d     = idx_q + {1'b0, sd_if.dp_tick};
      inc       = sd_if.fast_mode ? sd_if.fast_tick : sd_if.score_tick;

      case (state_q)
         IDLE: begin
            if (sd_if.start) begin
               state_d = RUN;
               score_d = '0;
            end
         end
         RUN: begin
            // game_over beats both start and a same-cycle increment
            if (sd_if.game_over) begin
               state_d = OVER;
               if (score_q > hi_q) hi_d = score_q;
            end else if (inc) begin
               score_d = bcd_inc(score_q);
            end
         end
         OVER: begin
            if (sd_if.start) begin
               state_d = RUN;
               score_d = '0;
            end else if (sd_if.blink_tick) begin
               visible_d = ~visible_q;
            end
         end
         default: state_d = IDLE;
      endcase

      if (state_d != OVER || state_q != OVER) visible_d = 1'b1;
   end

   always_comb begin
      shown = (state_q == IDLE) ? hi_q : score_q;
      digit = shown[{idx_q, 2'b00} +: 4];
      blank = (idx_q != 2'd0) && ((shown >> {idx_q, 2'b00}) == 16'h0000);
      pat   = blank ? 7'b1111111 : seg_lo(digit);
      seg_d = SEG_ACTIVE_LOW ? pat : ~pat;
      an_d  = visible_q ? ~(4'b0001 << idx_q) : 4'b1111;
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         score_q   <= '0;
         hi_q      <= '0;
         idx_q     <= '0;
         visible_q <= 1'b1;
         an_q      <= 4'b1111;
         seg_q     <= SEG_OFF;
      end else begin
         state_q   <= state_d;
         score_q   <= score_d;
         hi_q      <= hi_d;
         idx_q     <= idx_d;
         visible_q <= visible_d;
         an_q      <= an_d;
         seg_q     <= seg_d;
      end
   end

   assign sd_if.score_bcd = score_q;
   assign sd_if.hi_bcd    = hi_q;
   assign sd_if.an        = an_q;
   assign sd_if.seg       = seg_q;
   assign sd_if.dp        = SEG_ACTIVE_LOW;

endmodule
